// File: rtl/adc_pkg.sv
// Shared constants and FSM state encoding for the ADC128S102 responder model.
package adc_pkg;

    localparam int unsigned NUM_CH         = 8;
    localparam int unsigned DATA_W         = 12;
    localparam int unsigned FRAME_BITS     = 16;
    localparam int unsigned ADDR_FIRST_BIT = 2;
    localparam int unsigned ADDR_W         = 3;

    // Bit counter must hold 0..FRAME_BITS inclusive.
    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

    // After a full frame the first din bit sits in the control register MSB,
    // so ADD2 (sampled on rising edge ADDR_FIRST_BIT+1) lands at this index.
    localparam int unsigned ADDR_MSB_IDX = FRAME_BITS - 1 - ADDR_FIRST_BIT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses on the
// synchronized level.
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronized level (registered)
//   rise_c     : one-cycle pulse when q goes 0->1
//   fall_c     : one-cycle pulse when q goes 1->0
module edge_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] chain;
    logic              q_prev;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain  <= {STAGES{RST_VAL}};
            q_prev <= RST_VAL;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                chain[i] <= chain[i-1];
            end
            q_prev <= chain[STAGES-1];
        end
    end

    assign q      = chain[STAGES-1];
    assign rise_c = q & ~q_prev;
    assign fall_c = ~q & q_prev;

endmodule

// File: rtl/adc128s102_responder.sv
// Behavioural responder for an ADC128S102 SPI ADC: returns one of eight
// channel values per 16-bit frame, addressed by the previous frame.
//   clk_32M    : system clock
//   rst_n      : async active-low reset
//   sck/cs/din : SPI from initiator (asynchronous, synchronized here)
//   ch_data    : eight DATA_W-bit channel values, channel n at [n*DATA_W +: DATA_W]
//   dout       : SPI data to initiator, MSB first
//   dout_oe    : DOUT drive enable (low = tri-stated)
//   frame_done : one-cycle pulse after a complete frame
//   cur_addr   : channel address latched from the last complete frame
module adc128s102_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_W      = 12
) (
    input  logic                                clk_32M,
    input  logic                                rst_n,
    input  logic                                sck,
    input  logic                                cs,
    input  logic                                din,
    input  logic [adc_pkg::NUM_CH*DATA_W-1:0]   ch_data,
    output logic                                dout,
    output logic                                dout_oe,
    output logic                                frame_done,
    output logic [adc_pkg::ADDR_W-1:0]          cur_addr
);

    import adc_pkg::*;

    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(FRAME_BITS);
    localparam int unsigned         FLUSH_W  = $clog2(SYNC_STAGES + 1);

    // Synchronized inputs and edge pulses
    logic sck_lvl_unused, sck_rise_c, sck_fall_c;
    logic cs_s, cs_rise_unused, cs_fall_c;
    logic din_s, din_rise_unused, din_fall_unused;

    edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
        .clk    (clk_32M),
        .rst_n  (rst_n),
        .d      (sck),
        .q      (sck_lvl_unused),
        .rise_c (sck_rise_c),
        .fall_c (sck_fall_c)
    );

    edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk    (clk_32M),
        .rst_n  (rst_n),
        .d      (cs),
        .q      (cs_s),
        .rise_c (cs_rise_unused),
        .fall_c (cs_fall_c)
    );

    edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
        .clk    (clk_32M),
        .rst_n  (rst_n),
        .d      (din),
        .q      (din_s),
        .rise_c (din_rise_unused),
        .fall_c (din_fall_unused)
    );

    // Registered state
    state_e                  state, state_nxt;
    logic [FRAME_BITS-1:0]   sr, sr_nxt;
    logic [FRAME_BITS-1:0]   ctrl, ctrl_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0]       addr_nxt;
    logic                    done_nxt;
    logic                    dout_r, dout_nxt;
    logic [FLUSH_W-1:0]      flush_cnt;
    logic                    flushed;
    logic                    armed;
    logic [DATA_W-1:0]       ch_sel;

    // The synchronizers reset to cs=1; until they have flushed, a low cs
    // looks like a falling edge. Arm only once cs is genuinely seen high so
    // a reset released mid-frame cannot start a frame.
    assign flushed = (flush_cnt == FLUSH_W'(SYNC_STAGES));

    assign ch_sel = ch_data[32'(cur_addr) * DATA_W +: DATA_W];

    // State and datapath registers
    always_ff @(posedge clk_32M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            ctrl       <= '0;
            cnt        <= '0;
            cur_addr   <= '0;
            frame_done <= 1'b0;
            dout_r     <= 1'b0;
            flush_cnt  <= '0;
            armed      <= 1'b0;
        end else begin
            state      <= state_nxt;
            sr         <= sr_nxt;
            ctrl       <= ctrl_nxt;
            cnt        <= cnt_nxt;
            cur_addr   <= addr_nxt;
            frame_done <= done_nxt;
            dout_r     <= dout_nxt;
            if (!flushed) begin
                flush_cnt <= flush_cnt + FLUSH_W'(1);
            end
            armed <= armed | (flushed & cs_s);
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        ctrl_nxt  = ctrl;
        cnt_nxt   = cnt;
        addr_nxt  = cur_addr;
        done_nxt  = 1'b0;
        dout_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (cs_fall_c && armed) begin
                    state_nxt = LOAD;
                end
            end

            LOAD: begin
                if (cs_s) begin
                    state_nxt = IDLE;
                end else begin
                    sr_nxt    = {{(FRAME_BITS - DATA_W){1'b0}}, ch_sel};
                    ctrl_nxt  = '0;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                if (cs_s) begin
                    // Aborted frame: address and done pulse untouched.
                    state_nxt = IDLE;
                end else if (sck_rise_c) begin
                    ctrl_nxt = {ctrl[FRAME_BITS-2:0], din_s};
                    if (cnt != CNT_FULL) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                    if (cnt_nxt == CNT_FULL) begin
                        addr_nxt  = ctrl_nxt[ADDR_MSB_IDX -: ADDR_W];
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (sck_fall_c && cnt != '0 && cnt != CNT_FULL) begin
                    sr_nxt = {sr[FRAME_BITS-2:0], 1'b0};
                end
            end

            DONE: begin
                if (cs_s) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase

        if (state_nxt == SHIFT && cnt_nxt != CNT_FULL) begin
            dout_nxt = sr_nxt[FRAME_BITS-1];
        end
    end

    // Drive only while selected and armed; dout is forced low when not driven.
    assign dout_oe = ~cs_s & armed;
    assign dout    = dout_r & dout_oe;

endmodule

// File: tb/tb_adc128s102_responder.sv
// Directed bench for adc128s102_responder: table of full frames plus
// hand-written abort, mid-frame data change, over-long frame, idle sck
// and reset-mid-frame sequences.
module tb_adc128s102_responder;

    localparam int HALF = 80;  // sck half period: sck = clk/16

    logic        clk_32M = 1'b0;
    logic        rst_n;
    logic        sck;
    logic        cs;
    logic        din;
    logic [95:0] ch_data;
    logic        dout;
    logic        dout_oe;
    logic        frame_done;
    logic [2:0]  cur_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int done_total = 0;

    localparam logic [95:0] CH_DEF = {12'h5A5, 12'h0FF, 12'h123, 12'hF00,
                                      12'hDEF, 12'h789, 12'h456, 12'hABC};

    typedef struct {
        logic [15:0] din_word;
        logic [15:0] exp_dout;
        logic [2:0]  exp_addr;
    } vec_t;

    vec_t vecs[8];

    always #5 clk_32M = ~clk_32M;

    adc128s102_responder #(.SYNC_STAGES(2), .DATA_W(12)) dut (
        .clk_32M    (clk_32M),
        .rst_n      (rst_n),
        .sck        (sck),
        .cs         (cs),
        .din        (din),
        .ch_data    (ch_data),
        .dout       (dout),
        .dout_oe    (dout_oe),
        .frame_done (frame_done),
        .cur_addr   (cur_addr)
    );

    // Counts high cycles, so a pulse longer than one cycle shows up as >1.
    always @(negedge clk_32M) begin
        if (frame_done === 1'b1) done_total++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cs-low window with npulse sck pulses; dout sampled just before
    // each rising edge, as the initiator would.
    task automatic run_frame(input logic [15:0] w, input int npulse,
                             input int change_at, input logic [95:0] ch_alt,
                             output logic [15:0] got, output logic tail_bad,
                             output logic oe_bad);
        got = '0;
        tail_bad = 1'b0;
        oe_bad = 1'b0;
        cs = 1'b0;
        #(HALF);
        for (int i = 0; i < npulse; i++) begin
            sck = 1'b0;
            din = (i < 16) ? w[15-i] : 1'b0;
            #(HALF);
            if (i < 16) got[15-i] = dout;
            else if (dout !== 1'b0) tail_bad = 1'b1;
            if (dout_oe !== 1'b1) oe_bad = 1'b1;
            sck = 1'b1;
            if (i == change_at) ch_data = ch_alt;
            #(HALF);
        end
        cs = 1'b1;
        din = 1'b0;
        #(4*HALF);
    endtask

    initial begin
        logic [15:0] got;
        logic        tail_bad, oe_bad, bad;
        int          d0;
        logic [95:0] ch_ff, ch_00;

        vecs[0] = '{16'h0000, 16'h0ABC, 3'd0};
        vecs[1] = '{16'h2800, 16'h0ABC, 3'd5};
        vecs[2] = '{16'h3800, 16'h0123, 3'd7};
        vecs[3] = '{16'h0800, 16'h05A5, 3'd1};
        vecs[4] = '{16'h1000, 16'h0456, 3'd2};
        vecs[5] = '{16'hC7FF, 16'h0789, 3'd0};
        vecs[6] = '{16'h1800, 16'h0ABC, 3'd3};
        vecs[7] = '{16'h2000, 16'h0DEF, 3'd4};

        rst_n = 1'b0;
        cs = 1'b1;
        sck = 1'b1;
        din = 1'b0;
        ch_data = CH_DEF;
        #2;
        #40;
        check("reset dout", 32'(dout), 32'd0);
        check("reset dout_oe", 32'(dout_oe), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset cur_addr", 32'(cur_addr), 32'd0);
        rst_n = 1'b1;
        #(2*HALF);

        // Full frames from the table
        for (int i = 0; i < 8; i++) begin
            d0 = done_total;
            run_frame(vecs[i].din_word, 16, -1, CH_DEF, got, tail_bad, oe_bad);
            check($sformatf("vec%0d dout", i), 32'(got), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d frame_done", i), 32'(done_total - d0), 32'd1);
            check($sformatf("vec%0d cur_addr", i), 32'(cur_addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d dout_oe", i), 32'(oe_bad), 32'd0);
        end

        // Abort after 9 rising edges with ADD=7
        d0 = done_total;
        run_frame(16'h3800, 9, -1, CH_DEF, got, tail_bad, oe_bad);
        check("abort frame_done", 32'(done_total - d0), 32'd0);
        check("abort cur_addr", 32'(cur_addr), 32'd4);
        check("abort idle dout_oe", 32'(dout_oe), 32'd0);
        d0 = done_total;
        run_frame(16'h0000, 16, -1, CH_DEF, got, tail_bad, oe_bad);
        check("post-abort dout", 32'(got), 32'h0F00);
        check("post-abort frame_done", 32'(done_total - d0), 32'd1);
        check("post-abort cur_addr", 32'(cur_addr), 32'd0);

        // ch0 changes from FFF to 000 mid-frame
        ch_ff = CH_DEF;
        ch_ff[11:0] = 12'hFFF;
        ch_00 = CH_DEF;
        ch_00[11:0] = 12'h000;
        ch_data = ch_ff;
        d0 = done_total;
        run_frame(16'h0000, 16, 6, ch_00, got, tail_bad, oe_bad);
        check("midchange dout", 32'(got), 32'h0FFF);
        check("midchange frame_done", 32'(done_total - d0), 32'd1);
        ch_data = CH_DEF;

        // 20 sck pulses in one window
        d0 = done_total;
        run_frame(16'h2800, 20, -1, CH_DEF, got, tail_bad, oe_bad);
        check("long dout", 32'(got), 32'h0ABC);
        check("long frame_done", 32'(done_total - d0), 32'd1);
        check("long tail dout", 32'(tail_bad), 32'd0);
        check("long cur_addr", 32'(cur_addr), 32'd5);

        // sck toggling with cs high
        d0 = done_total;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sck = 1'b0;
            #(HALF);
            if (dout_oe !== 1'b0 || dout !== 1'b0) bad = 1'b1;
            sck = 1'b1;
            #(HALF);
        end
        check("cs-high sck outputs", 32'(bad), 32'd0);
        check("cs-high sck frame_done", 32'(done_total - d0), 32'd0);

        // Reset asserted mid-frame, cs stays low afterwards
        cs = 1'b0;
        #(HALF);
        for (int i = 0; i < 6; i++) begin
            sck = 1'b0;
            din = 1'b1;
            #(HALF);
            sck = 1'b1;
            #(HALF);
        end
        sck = 1'b0;
        #(HALF/2);
        rst_n = 1'b0;
        #1;
        check("midreset dout", 32'(dout), 32'd0);
        check("midreset dout_oe", 32'(dout_oe), 32'd0);
        check("midreset frame_done", 32'(frame_done), 32'd0);
        check("midreset cur_addr", 32'(cur_addr), 32'd0);
        #29;
        rst_n = 1'b1;
        #(HALF);
        d0 = done_total;
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sck = 1'b0;
            din = 1'b0;
            #(HALF);
            if (dout_oe !== 1'b0 || dout !== 1'b0) bad = 1'b1;
            sck = 1'b1;
            #(HALF);
        end
        check("postreset quiet outputs", 32'(bad), 32'd0);
        check("postreset quiet frame_done", 32'(done_total - d0), 32'd0);
        cs = 1'b1;
        #(4*HALF);
        d0 = done_total;
        run_frame(16'h0000, 16, -1, CH_DEF, got, tail_bad, oe_bad);
        check("postreset frame dout", 32'(got), 32'h0ABC);
        check("postreset frame_done", 32'(done_total - d0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc128s102_responder.md
ADC128S102_RESPONDER -- requirements
Module: adc128s102_responder

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on sck/cs/din.
REQ-002 Parameter: DATA_W, default 12, conversion result width.
REQ-003 Port: clk_32M  input  1  sole clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: sck  input  1  SPI serial clock from initiator, asynchronous to clk_32M.
REQ-006 Port: cs  input  1  SPI chip select from initiator, active-low, asynchronous.
REQ-007 Port: din  input  1  SPI control data from initiator, sampled on sck rising.
REQ-008 Port: ch_data  input  96  eight 12-bit channel values; channel n at bits [12n+11:12n].
REQ-009 Port: dout  output  1  SPI conversion data to initiator, MSB first.
REQ-010 Port: dout_oe  output  1  high while cs low (models DOUT tri-state).
REQ-011 Port: frame_done  output  1  one-cycle pulse after a complete 16-bit frame.
REQ-012 Port: cur_addr  output  3  channel address latched from the last complete frame.

Function
REQ-013 sck, cs, din SHALL each pass through SYNC_STAGES flops before use; edges detected on synchronized values.
REQ-014 Supported sck frequency SHALL be at most clk_32M/8; faster sck is out of scope.
REQ-015 FSM states: IDLE, LOAD, SHIFT, DONE.
REQ-016 IDLE -> LOAD on synchronized cs falling edge; LOAD captures ch_data[cur_addr] into a 16-bit shift register {4'b0000, value}, clears bit counter, lasts one cycle, -> SHIFT.
REQ-017 In SHIFT, dout SHALL equal shift register bit 15; first bit (0) presented from LOAD exit, before first sck falling edge.
REQ-018 On each synchronized sck rising edge in SHIFT: din sampled into a 16-bit control register; bit counter increments (0..16, saturates at 16).
REQ-019 On each synchronized sck falling edge in SHIFT with counter 1..15: shift register shifts left by one, zero fill.
REQ-020 Control register bits sampled on rising edges 3,4,5 (counter values 2,3,4 before increment) form ADD2..ADD0, MSB first.
REQ-021 Counter reaching 16 -> DONE; DONE updates cur_addr with captured ADD2..ADD0, pulses frame_done for exactly one cycle, -> IDLE when cs synchronized high (waits in DONE otherwise, no further effect of sck).
REQ-022 Address selection is pipelined: frame k returns data of the channel addressed in frame k-1; first frame after reset returns channel 0.
REQ-023 cs rising in LOAD or SHIFT with counter < 16: frame aborted, -> IDLE, cur_addr unchanged, no frame_done.
REQ-024 sck edges while cs high SHALL be ignored.
REQ-025 dout_oe SHALL equal NOT synchronized cs; dout SHALL be 0 whenever dout_oe is 0 or counter = 16.
REQ-026 ch_data sampled only in LOAD; changes during SHIFT do not affect the current frame.
REQ-027 dout SHALL update within SYNC_STAGES+1 clk_32M cycles of an sck falling edge.

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, dout 0, dout_oe 0, frame_done 0, cur_addr 0, counter 0, shift and control registers 0, synchronizers to cs=1, sck=1, din=0.
REQ-029 Reset deassertion mid-frame (cs already low) SHALL NOT start a frame; a new cs falling edge is required.

Structure
REQ-030 Package adc_pkg SHALL hold NUM_CH=8, DATA_W=12, FRAME_BITS=16, ADDR_FIRST_BIT=2, and the FSM state enumeration.
REQ-031 One sub-module edge_sync (synchronizer plus rise/fall pulse outputs, reset value parameter) SHALL be instantiated for sck, cs, din.

Verification
REQ-032 Reset, ch_data ch0=12'hABC, one frame din=16'h0000, sck=clk/16 -> dout bits 0000_1010_1011_1100, frame_done once, cur_addr 0.
REQ-033 Frame 1 din=16'h2800 (ADD=5), frame 2 any din, ch5=12'h123 -> frame 1 returns ch0, frame 2 returns 0000_0001_0010_0011, cur_addr 5 after frame 1.
REQ-034 cs raised after 9 sck rising edges with ADD=7 -> no frame_done, cur_addr unchanged, next frame returns previously addressed channel.
REQ-035 ch_data changed mid-SHIFT from 12'hFFF to 12'h000 -> frame still returns 12'hFFF.
REQ-036 rst_n pulsed low mid-frame -> all outputs 0 immediately; cs held low afterwards -> no output activity until cs rises and falls again.
REQ-037 20 sck pulses in one cs-low window -> exactly one frame_done, dout 0 after bit 16.
